uart_rx_buffer: RTL and testbench

UART receiver with an integrated receive FIFO. It deserializes the serial line driven by the UART checker's o_tx (or by a DUT TX pin) and stores the received words in a buffer. The testbench sequencer reads those words back in order and compares them with expected values. The block sits directly downstream of the UART checker TX path and replaces the plain loopback wire as the consumer of transmitted frames.

---
 rtl/uart_rx_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART receiver feeding a show-ahead circular FIFO, with sticky parity, framing
// and overflow flags. Every sample is taken mid-bit, timed from the start edge.
module uart_rx_buffer #(
    parameter int G_CLOCK_FREQ        = 20000000,
    parameter int G_BAUDRATE          = 2000000,
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_PARITY            = 0,
    parameter int G_STOP_BIT_NUMBER   = 1,
    parameter int G_FIRST_BIT         = 0,
    parameter int G_POLARITY          = 1,
    parameter int G_BUFFER_ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_rx,
    input  logic                           i_rd_en,
    input  logic                           i_clr,
    output logic [G_DATA_WIDTH-1:0]        o_rx_data,
    output logic                           o_rx_valid,
    output logic [G_BUFFER_ADDR_WIDTH:0]   o_fifo_count,
    output logic                           o_full,
    output logic                           o_parity_err,
    output logic                           o_frame_err,
    output logic                           o_overflow,
    output logic                           o_busy
);

    localparam int N     = G_CLOCK_FREQ / G_BAUDRATE;
    localparam int CW    = $clog2(N);
    localparam int IW    = $clog2(G_DATA_WIDTH + 1);
    localparam int AW    = G_BUFFER_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    localparam logic [CW-1:0] HALF_C     = CW'(N / 2);
    localparam logic [CW-1:0] LAST_C     = CW'(N - 1);
    localparam logic [IW-1:0] DATA_LAST  = IW'(G_DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST  = IW'(G_STOP_BIT_NUMBER - 1);
    localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
    localparam logic          IDLE_LVL   = (G_POLARITY != 0);
    localparam logic          ODD_PARITY = (G_PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_reg;
    logic [1:0]                sync_reg;
    logic                      line;
    logic                      line_prev_reg;
    logic [CW-1:0]             cnt_reg;
    logic [IW-1:0]             idx_reg;
    logic [G_DATA_WIDTH-1:0]   shift_reg;
    logic                      frame_bad_reg;
    logic                      par_bad_reg;
    logic                      commit_reg;

    logic [G_DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]             rd_ptr_reg;
    logic [AW-1:0]             wr_ptr_reg;
    logic [AW:0]               count_reg;
    logic                      parity_err_reg;
    logic                      frame_err_reg;
    logic                      overflow_reg;

    logic                      pop;
    logic                      wr_req;
    logic                      full_after_pop;
    logic                      do_write;

    // Synchronizer idles at the raw line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {2{IDLE_LVL}};
        end else begin
            sync_reg <= {sync_reg[0], i_rx};
        end
    end

    assign line = sync_reg[1] ^ ~IDLE_LVL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            line_prev_reg <= 1'b1;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            frame_bad_reg <= 1'b0;
            par_bad_reg   <= 1'b0;
            commit_reg    <= 1'b0;
        end else begin
            line_prev_reg <= line;
            commit_reg    <= 1'b0;
            cnt_reg       <= cnt_reg + 1'b1;
            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (line_prev_reg && !line) begin
                        state_reg     <= S_START;
                        idx_reg       <= '0;
                        frame_bad_reg <= 1'b0;
                        par_bad_reg   <= 1'b0;
                    end
                end
                S_START: begin
                    // Restarting the counter here puts later samples at mid-bit.
                    if (cnt_reg == HALF_C) begin
                        cnt_reg   <= '0;
                        state_reg <= line ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == LAST_C) begin
                        cnt_reg <= '0;
                        if (G_FIRST_BIT == 0) begin
                            shift_reg <= {line, shift_reg[G_DATA_WIDTH-1:1]};
                        end else begin
                            shift_reg <= {shift_reg[G_DATA_WIDTH-2:0], line};
                        end
                        if (idx_reg == DATA_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= (G_PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt_reg == LAST_C) begin
                        cnt_reg     <= '0;
                        par_bad_reg <= ((^shift_reg) ^ line) != ODD_PARITY;
                        state_reg   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_reg == LAST_C) begin
                        cnt_reg <= '0;
                        if (!line) begin
                            frame_bad_reg <= 1'b1;
                        end
                        if (idx_reg == STOP_LAST) begin
                            idx_reg    <= '0;
                            state_reg  <= S_IDLE;
                            commit_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Full check is made after this cycle's pop so a simultaneous read frees a slot.
    assign pop            = i_rd_en && (count_reg != '0);
    assign wr_req         = commit_reg && !frame_bad_reg;
    assign full_after_pop = (count_reg == DEPTH_C) && !pop;
    assign do_write       = wr_req && !full_after_pop && !i_clr;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else if (i_clr) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (commit_reg && frame_bad_reg) begin
                frame_err_reg <= 1'b1;
            end
            if (wr_req && par_bad_reg) begin
                parity_err_reg <= 1'b1;
            end
            if (wr_req && full_after_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign o_rx_valid   = (count_reg != '0);
    assign o_rx_data    = o_rx_valid ? mem[rd_ptr_reg] : '0;
    assign o_fifo_count = count_reg;
    assign o_full       = (count_reg == DEPTH_C);
    assign o_parity_err = parity_err_reg;
    assign o_frame_err  = frame_err_reg;
    assign o_overflow   = overflow_reg;
    assign o_busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: a default-format receiver and an even-parity receiver,
// driven with serial frames and checked against a queue-based reference model.
module tb_uart_rx_buffer;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rd_a = 1'b0, clr_a = 1'b0;
    logic       rx_p = 1'b1, rd_p = 1'b0, clr_p = 1'b0;
    logic [7:0] data_a, data_p;
    logic [4:0] count_a, count_p;
    logic       valid_a, full_a, perr_a, ferr_a, ovf_a, busy_a;
    logic       valid_p, full_p, perr_p, ferr_p, ovf_p, busy_p;

    int tests_run = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    bit         m_ferr = 1'b0;
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_buffer dut_a (
        .clk(clk), .rst_n(rst_n), .i_rx(rx_a), .i_rd_en(rd_a), .i_clr(clr_a),
        .o_rx_data(data_a), .o_rx_valid(valid_a), .o_fifo_count(count_a),
        .o_full(full_a), .o_parity_err(perr_a), .o_frame_err(ferr_a),
        .o_overflow(ovf_a), .o_busy(busy_a)
    );

    uart_rx_buffer #(.G_PARITY(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .i_rx(rx_p), .i_rd_en(rd_p), .i_clr(clr_p),
        .o_rx_data(data_p), .o_rx_valid(valid_p), .o_fifo_count(count_p),
        .o_full(full_p), .o_parity_err(perr_p), .o_frame_err(ferr_p),
        .o_overflow(ovf_p), .o_busy(busy_p)
    );

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_p = v; else rx_a = v;
        repeat (N) @(posedge clk);
        #1;
    endtask

    // LSB-first frame; sel=1 targets the even-parity receiver.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_flip,
                              input logic stop_val);
        @(posedge clk);
        #1;
        drive_bit(sel, 1'b0);
        for (int b = 0; b < 8; b++) drive_bit(sel, d[b]);
        if (sel) drive_bit(sel, (^d) ^ par_flip);
        drive_bit(sel, stop_val);
        if (sel) rx_p = 1'b1; else rx_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one received frame on the default receiver.
    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit pop_same);
        if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
        if (!stop_ok) m_ferr = 1'b1;
        else if (exp_q.size() == 16) m_ovf = 1'b1;
        else exp_q.push_back(d);
    endtask

    task automatic pop_a();
        rd_a = 1'b1;
        @(posedge clk);
        #1;
        rd_a = 1'b0;
    endtask

    task automatic clear_both();
        clr_a = 1'b1;
        clr_p = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        clr_p = 1'b0;
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        tests_run++;
        if ({valid_a, count_a, full_a, perr_a, ferr_a, ovf_a, busy_a, data_a} !== '0) begin
            fails++;
            $display("FAIL reset_a: outputs=%h required 0",
                     {valid_a, count_a, full_a, perr_a, ferr_a, ovf_a, busy_a, data_a});
        end
        tests_run++;
        if ({valid_p, count_p, full_p, perr_p, ferr_p, ovf_p, busy_p, data_p} !== '0) begin
            fails++;
            $display("FAIL reset_p: outputs=%h required 0",
                     {valid_p, count_p, full_p, perr_p, ferr_p, ovf_p, busy_p, data_p});
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] reset released");
    endtask

    task automatic test_single();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        tests_run++;
        if (valid_a !== 1'b1 || data_a !== 8'hA5 || count_a !== 5'd1 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL single_rx: valid=%b data=%h count=%0d busy=%b required 1 a5 1 0",
                     valid_a, data_a, count_a, busy_a);
        end
        pop_a();
        void'(exp_q.pop_front());
        tests_run++;
        if (valid_a !== 1'b0 || count_a !== 5'd0) begin
            fails++;
            $display("FAIL single_pop: valid=%b count=%0d required 0 0", valid_a, count_a);
        end
        $display("[TB] single frame a5 received and popped");
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i <= 16; i++) begin
            send_frame(1'b0, 8'(i), 1'b0, 1'b1);
            model_frame(8'(i), 1'b1, 1'b0);
            if (i == 15) begin
                tests_run++;
                if (full_a !== 1'b1 || ovf_a !== 1'b0 || count_a !== 5'd16) begin
                    fails++;
                    $display("FAIL fill_16: full=%b ovf=%b count=%0d required 1 0 16",
                             full_a, ovf_a, count_a);
                end
            end
        end
        tests_run++;
        if (ovf_a !== m_ovf || count_a !== 5'(exp_q.size())) begin
            fails++;
            $display("FAIL overflow_17: ovf=%b count=%0d required %b %0d",
                     ovf_a, count_a, m_ovf, exp_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (data_a !== exp_q[0] || valid_a !== 1'b1) begin
                fails++;
                $display("FAIL fill_read%0d: data=%h valid=%b required %h 1",
                         i, data_a, valid_a, exp_q[0]);
            end
            pop_a();
            void'(exp_q.pop_front());
        end
        clear_both();
        tests_run++;
        if (ovf_a !== 1'b0 || count_a !== 5'd0 || full_a !== 1'b0) begin
            fails++;
            $display("FAIL clr_ovf: ovf=%b count=%0d full=%b required 0 0 0",
                     ovf_a, count_a, full_a);
        end
        $display("[TB] fill/overflow sequence done");
    endtask

    task automatic test_parity();
        send_frame(1'b1, 8'h07, 1'b1, 1'b1);
        tests_run++;
        if (count_p !== 5'd1 || data_p !== 8'h07 || perr_p !== 1'b1 || ferr_p !== 1'b0) begin
            fails++;
            $display("FAIL parity_bad: count=%0d data=%h perr=%b ferr=%b required 1 07 1 0",
                     count_p, data_p, perr_p, ferr_p);
        end
        send_frame(1'b1, 8'h07, 1'b0, 1'b1);
        tests_run++;
        if (count_p !== 5'd2 || perr_p !== 1'b1) begin
            fails++;
            $display("FAIL parity_good: count=%0d perr=%b required 2 1", count_p, perr_p);
        end
        clear_both();
        send_frame(1'b1, 8'h5C, 1'b0, 1'b1);
        tests_run++;
        if (count_p !== 5'd1 || data_p !== 8'h5C || perr_p !== 1'b0) begin
            fails++;
            $display("FAIL parity_clean: count=%0d data=%h perr=%b required 1 5c 0",
                     count_p, data_p, perr_p);
        end
        clear_both();
        $display("[TB] parity frames done");
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        tests_run++;
        if (count_a !== 5'd0 || ferr_a !== 1'b1 || perr_a !== 1'b0) begin
            fails++;
            $display("FAIL frame_bad: count=%0d ferr=%b perr=%b required 0 1 0",
                     count_a, ferr_a, perr_a);
        end
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        tests_run++;
        if (count_a !== 5'd1 || data_a !== 8'h3C || ferr_a !== 1'b1) begin
            fails++;
            $display("FAIL frame_next: count=%0d data=%h ferr=%b required 1 3c 1",
                     count_a, data_a, ferr_a);
        end
        clear_both();
        $display("[TB] framing error sequence done");
    endtask

    task automatic test_glitch();
        bit seen_busy = 1'b0;
        bit dropped = 1'b0;
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_a = 1'b1;
        for (int k = 0; k < 40 && !dropped; k++) begin
            @(negedge clk);
            if (busy_a) seen_busy = 1'b1;
            else if (seen_busy) dropped = 1'b1;
        end
        tests_run++;
        if (!seen_busy || !dropped) begin
            fails++;
            $display("FAIL glitch_busy: seen_busy=%b dropped=%b required 1 1", seen_busy, dropped);
        end
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if (count_a !== 5'd0 || ferr_a !== 1'b0 || perr_a !== 1'b0 || ovf_a !== 1'b0
            || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL glitch_state: count=%0d ferr=%b perr=%b ovf=%b busy=%b required all 0",
                     count_a, ferr_a, perr_a, ovf_a, busy_a);
        end
        $display("[TB] glitch rejected");
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            logic [7:0] d = 8'($urandom);
            bit stop_ok = ($urandom_range(0, 7) != 0);
            int pops = $urandom_range(0, 2);
            send_frame(1'b0, d, 1'b0, stop_ok ? 1'b1 : 1'b0);
            model_frame(d, stop_ok, 1'b0);
            tests_run++;
            if (count_a !== 5'(exp_q.size()) || ferr_a !== m_ferr || ovf_a !== m_ovf
                || full_a !== (exp_q.size() == 16)) begin
                fails++;
                $display("FAIL rand_frame%0d: count=%0d ferr=%b ovf=%b full=%b required %0d %b %b %b",
                         f, count_a, ferr_a, ovf_a, full_a, exp_q.size(), m_ferr, m_ovf,
                         exp_q.size() == 16);
            end
            for (int p = 0; p < pops && exp_q.size() > 0; p++) begin
                tests_run++;
                if (data_a !== exp_q[0]) begin
                    fails++;
                    $display("FAIL rand_read%0d: data=%h required %h", f, data_a, exp_q[0]);
                end
                pop_a();
                void'(exp_q.pop_front());
            end
        end
        clear_both();
        $display("[TB] randomized frames done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] nw = 8'($urandom_range(1, 255));
        int k = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d = 8'($urandom_range(1, 255));
            send_frame(1'b0, d, 1'b0, 1'b1);
            model_frame(d, 1'b1, 1'b0);
        end
        tests_run++;
        if (full_a !== 1'b1 || count_a !== 5'd16) begin
            fails++;
            $display("FAIL b2b_fill: full=%b count=%0d required 1 16", full_a, count_a);
        end
        fork
            send_frame(1'b0, nw, 1'b0, 1'b1);
            begin
                while (!busy_a && k < 200) begin @(negedge clk); k++; end
                while (busy_a && k < 400) begin @(negedge clk); k++; end
                rd_a = 1'b1;
                @(posedge clk);
                #1;
                rd_a = 1'b0;
            end
        join
        model_frame(nw, 1'b1, 1'b1);
        tests_run++;
        if (k >= 400) begin
            fails++;
            $display("FAIL b2b_timeout: waited=%0d cycles required < 400", k);
        end
        tests_run++;
        if (count_a !== 5'd16 || ovf_a !== 1'b0 || full_a !== 1'b1) begin
            fails++;
            $display("FAIL b2b_commit: count=%0d ovf=%b full=%b required 16 0 1",
                     count_a, ovf_a, full_a);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (data_a !== exp_q[0]) begin
                fails++;
                $display("FAIL b2b_read%0d: data=%h required %h", i, data_a, exp_q[0]);
            end
            pop_a();
            void'(exp_q.pop_front());
        end
        $display("[TB] back-to-back pop and commit done, new word %h", nw);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(1'b0, 8'h11, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b1);
        fork
            send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
            begin
                repeat (35) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                tests_run++;
                if ({valid_a, count_a, full_a, perr_a, ferr_a, ovf_a, busy_a, data_a} !== '0) begin
                    fails++;
                    $display("FAIL reset_mid: outputs=%h required 0",
                             {valid_a, count_a, full_a, perr_a, ferr_a, ovf_a, busy_a, data_a});
                end
                #20;
                rst_n = 1'b1;
            end
        join
        repeat (300) @(posedge clk);
        #1;
        clear_both();
        tests_run++;
        if (count_a !== 5'd0 || busy_a !== 1'b0 || ferr_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_recover: count=%0d busy=%b ferr=%b required 0 0 0",
                     count_a, busy_a, ferr_a);
        end
        $display("[TB] reset mid-frame done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_parity();
        test_frame_err();
        test_glitch();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
